muldiv_sequencer: RTL and testbench
===================================

# muldiv_sequencer

Multi-cycle sequencer for the M-extension operations that the decode stage marks `alu_mstd`. It accepts one operation at a time from the execute stage, runs an iterative radix-2 shift-add multiply or restoring divide, and applies RISC-V special-case and sign rules. It returns a single-cycle `DONE` with the result while holding `BUSY` so the pipeline stalls. It supports RV64 full-width and `op_32` (W) variants.

## Interface
- `XLEN`, 64: datapath width; only 64 is supported.
- `CLK` input 1: clock; all state changes on the rising edge.
- `RST` input 1: one clock; reset is asynchronous and active-high.
- `START` input 1: request; sampled only in IDLE.
- `FUN3` input 3: M-extension funct3.
  - 0 mul, 1 mulh, 2 mulhsu, 3 mulhu, 4 div, 5 divu, 6 rem, 7 remu.
- `OP_32` input 1: W variant; operands are the low 32 bits; result is sign-extended from bit 31.
- `RS1` input XLEN: dividend or multiplicand; sampled at accept.
- `RS2` input XLEN: divisor or multiplier; sampled at accept.
- `FLUSH` input 1: synchronous abort; pipeline kill.
- `BUSY` output 1: high when state is not IDLE.
- `DONE` output 1: one-cycle result-valid pulse.
- `RESULT` output XLEN: final result; held until the next accept.

## Operation
- States: IDLE, RUN, FIX.
- **Accept:** occurs on a rising edge with state IDLE, `START`=1 and `FLUSH`=0.
  - Latch `FUN3` and `OP_32`.
  - Form operands:
    - Signed ops: take the absolute value and record the sign.
    - `OP_32` signed: sign-extend bit 31 first.
    - `OP_32` unsigned: zero-extend.
  - Load the iteration counter with N = 32 if `OP_32`, else 64.
  - Go to RUN, except for the special cases below.
- **Special cases:** these go straight to FIX with the result precomputed.
  - Divisor = 0:
    - div/divu give all ones in the operating width.
    - rem/remu give the dividend.
  - Signed overflow, where the dividend is the most negative value in the width and the divisor is −1:
    - div gives the dividend.
    - rem gives 0.
- **RUN:** one iteration per cycle; the counter decrements each cycle and RUN exits to FIX when it reaches 0.
  - Multiply: shift-add into a 2N-bit product register.
  - Divide: restoring shift-subtract producing an N-bit quotient and an N-bit remainder.
- **FIX:** select and correct the result.
  - mul: low N bits of the product.
  - mulh/mulhsu/mulhu: high N bits.
  - Negate the product if the operand signs differ (signed ops; mulhsu treats only `RS1` as signed).
  - Negate the quotient if the signs differ.
  - The remainder takes the dividend's sign.
  - `OP_32`: sign-extend bit 31 into [63:32].
  - `OP_32` with `FUN3` 1–3 is not a legal encoding and is executed as mulw.
  - On exit: register `RESULT`, pulse `DONE`, return to IDLE.
- **Ignored inputs:** `START` while `BUSY` is ignored; the operands are not resampled.
- **FLUSH:** at any state, the next edge returns to IDLE.
  - No `DONE` is issued and `RESULT` is unchanged.
  - `FLUSH` and `START` in the same IDLE cycle: flush wins and nothing is accepted.
- **Reset:** `RST` at any time, including mid-operation, forces the following:
  - State IDLE, `BUSY`=0, `DONE`=0, `RESULT`=0, counter 0.
  - Internal operand, sign and product registers cleared.

## Timing
- Accept on edge E0; iterations on edges E1..EN; FIX occupies the cycle after EN.
- `RESULT` and `DONE` are registered at edge E(N+1).
  - `DONE` is high for exactly the one cycle after E(N+1).
  - Latency from the accept edge to `DONE` high: 65 cycles for 64-bit ops, 33 for W ops.
- Special cases: E0 goes to FIX, and `DONE` is high in the cycle after E1 (1-cycle latency).
- `BUSY` is high from the cycle after E0 through the FIX cycle; it is low in the cycle `DONE` is high.
- Back-to-back: a `START` in the `DONE` cycle is accepted at that edge.
- All outputs are registered or decoded from the state register only; there is no combinational path from inputs to outputs.

## Test plan
- **Full-width signed multiply:** mul, `RS1`=7, `RS2`=−3 (0xFFFFFFFFFFFFFFFD), `OP_32`=0.
  - `RESULT`=0xFFFFFFFFFFFFFFEB; `DONE` high exactly 65 cycles after accept; `BUSY` high for 65 cycles.
- **High-word unsigned multiply:** mulhu with `RS1` = `RS2` = 0xFFFFFFFFFFFFFFFF.
  - `RESULT`=0xFFFFFFFFFFFFFFFE.
- **Same operands, high-word signed multiply:** mulh.
  - `RESULT`=0.
- **Divide by zero:** divu `RS1`=0x1234, `RS2`=0.
  - `RESULT`=0xFFFFFFFFFFFFFFFF, 1 cycle after accept.
- **Remainder by zero:** remu with the same operands.
  - `RESULT`=0x1234.
- **W overflow:** divw with `RS1` low 32 bits = 0x80000000, `RS2`=0xFFFFFFFF, `OP_32`=1.
  - `RESULT`=0xFFFFFFFF80000000, 1-cycle latency.
- **W remainder, signed:** remw, `RS1`=−7, `RS2`=2.
  - `RESULT`=0xFFFFFFFFFFFFFFFF (−1) after 33 cycles.
- **Flush and reset mid-operation:**
  - Assert `FLUSH` 10 cycles into a div: no `DONE`, `BUSY` low next cycle, old `RESULT` held.
  - Repeat with `RST` pulsed asynchronously mid-cycle: all outputs 0 immediately.
  - Then issue a new mul of 3 × 5: `RESULT`=15.

Source files
------------

// File: rtl/muldiv_sequencer_if.sv
// Request/response bundle between the execute stage and the multi-cycle mul/div sequencer.
// The execute stage drives the master side and the sequencer is the slave.
interface muldiv_sequencer_if #(
  parameter int XLEN = 64
);
  logic            start;
  logic [2:0]      fun3;
  logic            op_32;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic            flush;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, fun3, op_32, rs1, rs2, flush,
    input  busy, done, result
  );

  modport slave (
    input  start, fun3, op_32, rs1, rs2, flush,
    output busy, done, result
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative radix-2 multiply / restoring divide for the RISC-V M extension (RV64 and W forms).
// N+1 cycles from accept to DONE (N = 64 or 32), 1 cycle for divide special cases; FLUSH aborts silently.
module muldiv_sequencer #(
  parameter int XLEN = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  muldiv_sequencer_if.slave    bus
);
  localparam int CW = $clog2(XLEN + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t            state_q;
  logic [2:0]        fun3_q;
  logic              op32_q;
  logic [CW-1:0]     cnt_q;
  logic [2*XLEN-1:0] acc_q;
  logic [2*XLEN-1:0] mcand_q;
  logic [XLEN-1:0]   mplier_q;
  logic              neg_res_q;
  logic              neg_rem_q;
  logic              special_q;
  logic              done_q;
  logic [XLEN-1:0]   result_q;

  logic [2:0]        fun3_eff;
  logic              sgn_a, sgn_b, a_neg, b_neg;
  logic [XLEN-1:0]   opa_raw, opb_raw, a_abs, b_abs, min_val, special_val;
  logic              div_zero, div_ovf, special;

  // Operand conditioning at accept; illegal W high-multiplies collapse to mulw.
  always_comb begin
    fun3_eff = bus.fun3;
    if (bus.op_32 && (bus.fun3 inside {3'd1, 3'd2, 3'd3}))
      fun3_eff = 3'd0;
    sgn_a   = fun3_eff[2] ? ~fun3_eff[0] : (fun3_eff != 3'd3);
    sgn_b   = fun3_eff[2] ? ~fun3_eff[0] : ~fun3_eff[1];
    opa_raw = bus.rs1;
    opb_raw = bus.rs2;
    if (bus.op_32) begin
      opa_raw = {{(XLEN-32){sgn_a & bus.rs1[31]}}, bus.rs1[31:0]};
      opb_raw = {{(XLEN-32){sgn_b & bus.rs2[31]}}, bus.rs2[31:0]};
    end
    a_neg    = sgn_a & opa_raw[XLEN-1];
    b_neg    = sgn_b & opb_raw[XLEN-1];
    a_abs    = a_neg ? -opa_raw : opa_raw;
    b_abs    = b_neg ? -opb_raw : opb_raw;
    min_val  = bus.op_32 ? {{(XLEN-31){1'b1}}, 31'b0} : {1'b1, {(XLEN-1){1'b0}}};
    div_zero = (opb_raw == '0);
    div_ovf  = sgn_a && (opa_raw == min_val) && (opb_raw == '1);
    special  = fun3_eff[2] && (div_zero || div_ovf);
    if (div_zero)
      special_val = fun3_eff[1] ? opa_raw : '1;
    else
      special_val = fun3_eff[1] ? '0 : opa_raw;
  end

  logic [XLEN:0]     rem_sh;
  logic              div_ge;
  logic [XLEN-1:0]   rem_nx;
  logic [2*XLEN-1:0] acc_div_d, acc_mul_d;

  // acc_q holds the product for multiplies, {remainder, dividend/quotient} for divides.
  always_comb begin
    rem_sh    = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_ge    = (rem_sh >= {1'b0, mcand_q[XLEN-1:0]});
    rem_nx    = div_ge ? XLEN'(rem_sh - {1'b0, mcand_q[XLEN-1:0]}) : rem_sh[XLEN-1:0];
    acc_div_d = {rem_nx, acc_q[XLEN-2:0], div_ge};
    acc_mul_d = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
  end

  logic [2*XLEN-1:0] prod_n;
  logic [XLEN-1:0]   quo_n, rem_n, fix_sel, fix_res;

  always_comb begin
    prod_n = neg_res_q ? -acc_q : acc_q;
    quo_n  = neg_res_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem_n  = neg_rem_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    case (fun3_q)
      3'd0:          fix_sel = prod_n[XLEN-1:0];
      3'd4, 3'd5:    fix_sel = quo_n;
      3'd6, 3'd7:    fix_sel = rem_n;
      default:       fix_sel = prod_n[2*XLEN-1:XLEN];
    endcase
    if (special_q)
      fix_sel = acc_q[XLEN-1:0];
    fix_res = op32_q ? {{(XLEN-32){fix_sel[31]}}, fix_sel[31:0]} : fix_sel;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      fun3_q    <= '0;
      op32_q    <= 1'b0;
      cnt_q     <= '0;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      special_q <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
    end else begin
      done_q <= 1'b0;
      if (bus.flush) begin
        state_q <= IDLE;
      end else begin
        case (state_q)
          IDLE: if (bus.start) begin
            fun3_q    <= fun3_eff;
            op32_q    <= bus.op_32;
            cnt_q     <= bus.op_32 ? CW'(32) : CW'(XLEN);
            neg_res_q <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
            special_q <= special;
            mcand_q   <= {{XLEN{1'b0}}, fun3_eff[2] ? b_abs : a_abs};
            mplier_q  <= b_abs;
            if (special)
              acc_q <= {{XLEN{1'b0}}, special_val};
            else if (fun3_eff[2])
              acc_q <= {{XLEN{1'b0}}, bus.op_32 ? {a_abs[31:0], 32'b0} : a_abs};
            else
              acc_q <= '0;
            state_q <= special ? FIX : RUN;
          end
          RUN: begin
            if (fun3_q[2]) begin
              acc_q <= acc_div_d;
            end else begin
              acc_q    <= acc_mul_d;
              mcand_q  <= mcand_q << 1;
              mplier_q <= mplier_q >> 1;
            end
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == CW'(1))
              state_q <= FIX;
          end
          FIX: begin
            result_q <= fix_res;
            done_q   <= 1'b1;
            state_q  <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.busy   = (state_q != IDLE);
  assign bus.done   = done_q;
  assign bus.result = result_q;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed-vector bench for muldiv_sequencer: results, latency, BUSY span, flush and async reset.
module tb_muldiv_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;

  muldiv_sequencer_if #(.XLEN(64)) bus ();

  muldiv_sequencer #(.XLEN(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Issues one op in the current cycle; returns in the cycle DONE is high.
  task automatic run_op(input string tag, input logic [2:0] f3, input logic w,
                        input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] exp_res, input int exp_lat);
    int lat;
    int busy_cnt;
    @(negedge clk);
    bus.start = 1'b1; bus.fun3 = f3; bus.op_32 = w; bus.rs1 = a; bus.rs2 = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 0;
    busy_cnt = 0;
    while (!bus.done && lat < 200) begin
      if (bus.busy) busy_cnt++;
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_res"},  bus.result, exp_res);
    check({tag, "_lat"},  64'(lat), 64'(exp_lat));
    check({tag, "_busy"}, 64'(busy_cnt), 64'(exp_lat));
    check({tag, "_busy_in_done"}, {63'b0, bus.busy}, 64'd0);
  endtask

  initial begin
    int dn;
    bus.start = 1'b0; bus.fun3 = 3'd0; bus.op_32 = 1'b0;
    bus.rs1 = '0; bus.rs2 = '0; bus.flush = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_busy",   {63'b0, bus.busy}, 64'd0);
    check("rst_done",   {63'b0, bus.done}, 64'd0);
    check("rst_result", bus.result,        64'd0);

    run_op("mul_neg", 3'd0, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 65);
    @(posedge clk); #1;
    check("done_width", {63'b0, bus.done}, 64'd0);
    check("result_held", bus.result, 64'hFFFF_FFFF_FFFF_FFEB);

    run_op("mulhu", 3'd3, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 65);
    run_op("mulh",  3'd1, 1'b0, '1, '1, 64'd0, 65);
    run_op("mulhsu", 3'd2, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFF, 65);
    run_op("divu0", 3'd5, 1'b0, 64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    run_op("remu0", 3'd7, 1'b0, 64'h1234, 64'd0, 64'h1234, 1);
    run_op("divw_ovf", 3'd4, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF,
           64'hFFFF_FFFF_8000_0000, 1);
    run_op("div_ovf", 3'd4, 1'b0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1);
    run_op("rem_ovf", 3'd6, 1'b0, 64'h8000_0000_0000_0000, '1, 64'd0, 1);
    run_op("remw", 3'd6, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 33);
    run_op("divw", 3'd4, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 33);
    run_op("div",  3'd4, 1'b0, 64'd100, 64'd7, 64'd14, 65);
    run_op("rem_neg", 3'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 65);
    run_op("divu", 3'd5, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd16, 64'h0FFF_FFFF_FFFF_FFFF, 65);
    run_op("mulw", 3'd0, 1'b1, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 33);
    run_op("mulhw_as_mulw", 3'd1, 1'b1, 64'h1_0000_0003, 64'd5, 64'd15, 33);

    // Flush ten cycles into a divide; the mulw result must survive.
    @(negedge clk);
    bus.start = 1'b1; bus.fun3 = 3'd4; bus.op_32 = 1'b0; bus.rs1 = 64'd100; bus.rs2 = 64'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    check("flush_busy",   {63'b0, bus.busy}, 64'd0);
    check("flush_result", bus.result, 64'd15);
    dn = 0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #1;
      if (bus.done) dn++;
    end
    check("flush_no_done", 64'(dn), 64'd0);

    @(negedge clk);
    bus.start = 1'b1; bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.flush = 1'b0;
    check("flush_beats_start", {63'b0, bus.busy}, 64'd0);

    // Asynchronous reset mid-cycle during a divide.
    @(negedge clk);
    bus.start = 1'b1; bus.fun3 = 3'd4; bus.rs1 = 64'd100; bus.rs2 = 64'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_busy",   {63'b0, bus.busy}, 64'd0);
    check("arst_done",   {63'b0, bus.done}, 64'd0);
    check("arst_result", bus.result,        64'd0);
    @(negedge clk);
    rst = 1'b0;

    // START while busy must not resample operands.
    fork
      run_op("mul_3x5", 3'd0, 1'b0, 64'd3, 64'd5, 64'd15, 65);
      begin
        repeat (6) @(posedge clk);
        @(negedge clk);
        bus.start = 1'b1; bus.rs1 = 64'd9; bus.rs2 = 64'd9;
        @(negedge clk);
        bus.start = 1'b0;
      end
    join

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
